// File: rtl/instr_link_pkg.sv
// instr_link_pkg: shared state encodings and widths for the FPGA<->MBED instruction link
package instr_link_pkg;
    localparam int INSTR_WIDTH = 10;
    localparam int STATE_W     = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        REQ     = 3'd2,
        RELEASE = 3'd3,
        DONE    = 3'd4
    } link_state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for an asynchronous single-bit handshake line
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;

    // Two back-to-back flops; active-low synchronous clear
    always_ff @(posedge clk) begin
        if (!reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/instruction_tx.sv
// instruction_tx: MSB-first bit-serial sender over a data_ready/data_ack four-phase handshake
module instruction_tx
    import instr_link_pkg::*;
#(
    parameter int WIDTH        = INSTR_WIDTH,
    parameter int SETUP_CYCLES = 2,
    parameter int ACK_TIMEOUT  = 50000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [WIDTH-1:0]   word_in,
    input  logic               data_ack,
    output logic               data_ready,
    output logic               data_bit,
    output logic               busy,
    output logic               done,
    output logic               timeout_err,
    output logic [STATE_W-1:0] state
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);
    localparam logic [3:0]    SETUP_MAX = 4'(SETUP_CYCLES - 1);
    localparam logic [TW-1:0] TO_MAX    = TW'(ACK_TIMEOUT - 1);

    link_state_t      state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [3:0]       setup_cnt_q, setup_cnt_d;
    logic [TW-1:0]    to_cnt_q, to_cnt_d;
    logic             timeout_d, ready_d, bit_d;
    logic             ack_s, waiting;

    sync_2ff u_ack_sync (
        .clk   (clk),
        .reset (reset),
        .d     (data_ack),
        .q     (ack_s)
    );

    assign busy  = state_q != IDLE;
    assign done  = state_q == DONE;
    assign state = state_q;

    // Next-state, datapath and timeout decisions; waiting marks cycles stalled on the peer
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        timeout_d = timeout_err;
        waiting   = 1'b0;
        case (state_q)
            IDLE: if (load) begin
                state_d   = SETUP;
                shreg_d   = word_in;
                bit_cnt_d = '0;
                timeout_d = 1'b0;
            end
            SETUP: begin
                waiting = ack_s;
                if (!ack_s && setup_cnt_q == SETUP_MAX)
                    state_d = REQ;
            end
            REQ: begin
                waiting = !ack_s;
                if (ack_s)
                    state_d = RELEASE;
            end
            RELEASE: begin
                waiting = ack_s;
                if (!ack_s) begin
                    shreg_d   = shreg_q << 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    state_d   = (bit_cnt_q == LAST_BIT) ? DONE : SETUP;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (waiting && to_cnt_q == TO_MAX) begin
            state_d   = IDLE;
            timeout_d = 1'b1;
        end
        setup_cnt_d = (state_d != state_q) ? '0 :
                      (state_q == SETUP && setup_cnt_q != SETUP_MAX) ? setup_cnt_q + 1'b1 : setup_cnt_q;
        to_cnt_d    = (state_d != state_q) ? '0 : waiting ? to_cnt_q + 1'b1 : to_cnt_q;
        ready_d     = state_d == REQ;
        bit_d       = (state_d == DONE) ? 1'b0 :
                      (state_d == SETUP && state_q != SETUP) ? shreg_d[WIDTH-1] : data_bit;
    end

    // State register plus registered handshake outputs so data_ready/data_bit never glitch
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            setup_cnt_q <= '0;
            to_cnt_q    <= '0;
            timeout_err <= 1'b0;
            data_ready  <= 1'b0;
            data_bit    <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            setup_cnt_q <= setup_cnt_d;
            to_cnt_q    <= to_cnt_d;
            timeout_err <= timeout_d;
            data_ready  <= ready_d;
            data_bit    <= bit_d;
        end
    end
endmodule

// File: tb/tb_instruction_tx.sv
// tb_instruction_tx: scoreboard bench with a handshake responder and a shift-left receiver model
module tb_instruction_tx;
    localparam int W = 10;

    logic         clk = 1'b0;
    logic         reset, load, data_ack;
    logic [W-1:0] word_in;
    logic         data_ready, data_bit, busy, done, timeout_err;
    logic [2:0]   state;

    int n_checks = 0;
    int n_fail   = 0;

    int           ack_mode = 0;
    int           rcnt = 0;
    logic         exp_q[$];
    logic         exp_bit, cur_bit, prev_dr = 1'b0;
    logic [W-1:0] rx_word = '0;
    int           pulses = 0, done_cnt = 0, dr_cycles = 0;

    instruction_tx #(.WIDTH(W), .SETUP_CYCLES(2), .ACK_TIMEOUT(20)) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .word_in     (word_in),
        .data_ack    (data_ack),
        .data_ready  (data_ready),
        .data_bit    (data_bit),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .state       (state)
    );

    always #5 clk = ~clk;

    // Responder: 0 = ack/release 3 cycles after data_ready changes, 1 = never ack, 2 = ack stuck high
    initial begin
        data_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ack_mode == 2) data_ack = 1'b1;
            else if (ack_mode == 1) data_ack = 1'b0;
            else if (data_ready != data_ack) begin
                rcnt++;
                if (rcnt == 3) begin
                    data_ack = data_ready;
                    rcnt = 0;
                end
            end else rcnt = 0;
        end
    end

    // Monitor: receiver model plus scoreboard compare on each data_ready rise
    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
            if (data_ready === 1'b1) dr_cycles++;
            if (data_ready === 1'b1 && prev_dr !== 1'b1) begin
                pulses++;
                rx_word = {rx_word[W-2:0], data_bit};
                cur_bit = data_bit;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL bit_unexpected: data_bit=%0b with nothing queued", data_bit);
                end else begin
                    exp_bit = exp_q.pop_front();
                    if (data_bit !== exp_bit) begin
                        n_fail++;
                        $display("FAIL bit_value: got %0b expected %0b (pulse %0d)", data_bit, exp_bit, pulses);
                    end
                end
            end else if (data_ready === 1'b1) begin
                n_checks++;
                if (data_bit !== cur_bit) begin
                    n_fail++;
                    $display("FAIL bit_stable: data_bit changed to %0b while data_ready high", data_bit);
                end
            end
            prev_dr = data_ready;
        end
    end

    task automatic send(input logic [W-1:0] w);
        @(negedge clk);
        word_in = w;
        load = 1'b1;
        for (int i = W - 1; i >= 0; i--) exp_q.push_back(w[i]);
        rx_word = '0;
        pulses = 0;
        done_cnt = 0;
        dr_cycles = 0;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s_done_wait: done=0 after 2000 cycles, expected 1", tag);
        end
    endtask

    task automatic check_word(input string tag, input logic [W-1:0] w);
        @(negedge clk);
        n_checks++;
        if (rx_word !== w) begin n_fail++; $display("FAIL %s_word: got %h expected %h", tag, rx_word, w); end
        n_checks++;
        if (pulses != W) begin n_fail++; $display("FAIL %s_pulses: got %0d expected %0d", tag, pulses, W); end
        n_checks++;
        if (done_cnt != 1) begin n_fail++; $display("FAIL %s_done_cnt: got %0d expected 1", tag, done_cnt); end
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL %s_idle: busy=%b done=%b expected 0/0", tag, busy, done); end
        n_checks++;
        if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL %s_terr: got %b expected 0", tag, timeout_err); end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL %s_queue: %0d bits left expected 0", tag, exp_q.size()); end
    endtask

    task automatic test_reset();
        n_checks++;
        if ({data_ready, data_bit, busy, done, timeout_err} !== 5'b0 || state !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy=%b bit=%b busy=%b done=%b terr=%b state=%0d expected all 0",
                     data_ready, data_bit, busy, done, timeout_err, state);
        end
    endtask

    task automatic test_basic();
        ack_mode = 0;
        send(10'b1011000110);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", busy); end
        wait_done("basic");
        check_word("basic", 10'b1011000110);
    endtask

    task automatic test_loopback();
        send(10'h2A5);
        wait_done("loop");
        check_word("loop", 10'h2A5);
    endtask

    task automatic test_timeout();
        bit seen = 1'b0;
        ack_mode = 1;
        send(10'h0CC);
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (timeout_err === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL to_wait: timeout_err=0 after 300 cycles, expected 1"); end
        n_checks++;
        if (dr_cycles != 20) begin n_fail++; $display("FAIL to_req_len: data_ready high %0d cycles expected 20", dr_cycles); end
        n_checks++;
        if (state !== 3'd0 || busy !== 1'b0 || data_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL to_idle: state=%0d busy=%b rdy=%b expected 0/0/0", state, busy, data_ready);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (done_cnt != 0) begin n_fail++; $display("FAIL to_no_done: done pulses %0d expected 0", done_cnt); end
        exp_q.delete();
        ack_mode = 0;
        send(10'h133);
        n_checks++;
        if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_clear: timeout_err=%b expected 0 after load", timeout_err); end
        wait_done("to_retry");
        check_word("to_retry", 10'h133);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 1000 && pulses < 5; i++) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (data_ready !== 1'b0 || busy !== 1'b0 || state !== 3'd0) begin
            n_fail++;
            $display("FAIL midreset: rdy=%b busy=%b state=%0d expected 0/0/0", data_ready, busy, state);
        end
        reset = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++;
        if (done_cnt != 0) begin n_fail++; $display("FAIL midreset_done: done pulses %0d expected 0", done_cnt); end
        exp_q.delete();
        send(10'h3FF);
        wait_done("after_reset");
        check_word("after_reset", 10'h3FF);
    endtask

    task automatic test_reset_during_word();
        send(10'h2D2);
        test_reset_mid();
    endtask

    task automatic test_load_ignored();
        send(10'h155);
        for (int i = 0; i < 1000 && pulses < 3; i++) @(negedge clk);
        word_in = 10'h000;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_done("ignore");
        check_word("ignore", 10'h155);
    endtask

    task automatic test_back_to_back();
        send(10'h0F0);
        wait_done("b2b_first");
        word_in = 10'h3FF;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        n_checks++;
        if (state !== 3'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_done_load: state=%0d busy=%b expected 0/0", state, busy);
        end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_queue: %0d bits left expected 0", exp_q.size()); end
        send(10'h30F);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: busy=%b expected 1", busy); end
        wait_done("b2b_second");
        check_word("b2b_second", 10'h30F);
    endtask

    task automatic test_ack_stuck();
        bit seen = 1'b0;
        int setup_n = 0;
        ack_mode = 2;
        repeat (5) @(negedge clk);
        send(10'h1E1);
        for (int i = 0; i < 300 && !seen; i++) begin
            if (timeout_err === 1'b1) seen = 1'b1;
            else begin
                if (state === 3'd1) setup_n++;
                @(negedge clk);
            end
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL stuck_wait: timeout_err=0 after 300 cycles, expected 1"); end
        n_checks++;
        if (setup_n != 20) begin n_fail++; $display("FAIL stuck_setup_len: %0d SETUP cycles expected 20", setup_n); end
        n_checks++;
        if (dr_cycles != 0) begin n_fail++; $display("FAIL stuck_no_req: data_ready high %0d cycles expected 0", dr_cycles); end
        n_checks++;
        if (state !== 3'd0 || done_cnt != 0) begin
            n_fail++;
            $display("FAIL stuck_idle: state=%0d done pulses=%0d expected 0/0", state, done_cnt);
        end
        exp_q.delete();
        ack_mode = 0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        load = 1'b0;
        word_in = '0;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b1;
        test_basic();
        test_loopback();
        test_timeout();
        test_reset_during_word();
        test_load_ignored();
        test_back_to_back();
        test_ack_stuck();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
